onehot_req_fsm: RTL and testbench
=================================

# onehot_req_fsm

Parametrised one-hot request state machine: accepts exactly one of N_CH request lines, holds a one-hot active state while that request persists, returns to idle when requests drop, and traps multi-request conflicts in a fault state with a timed clear. Optional blink (flasher) modulation of the active output. Generalises the team's fixed 4-input one-hot selector (idle plus 4 active states, no conflict handling) to any channel count, with registered state, fault reporting and a blink mode.

## Interface

- N_CH, 4, number of request channels (>= 2)
- BLINK_HALF, 8, cycles per half blink period (>= 1)
- CLR_CYC, 4, consecutive all-zero request cycles needed to leave CONFLICT (>= 1)

- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; one clock, no other clocks or resets
- req  input  N_CH  request lines, bit k = channel k; sampled every rising edge
- y  output  N_CH  channel outputs, at most one bit high
- state  output  N_CH+2  one-hot state: bit0 IDLE, bit k+1 ACT(k), bit N_CH+1 CONFLICT
- fault  output  1  high while in CONFLICT

## Operation

- States: IDLE, ACT(0..N_CH-1), CONFLICT; exactly one state bit set at all times.
- Classify req each cycle: ZERO (all 0), ONE(k) (only bit k set), MULTI (>= 2 bits set).
- IDLE: ZERO -> IDLE; ONE(k) -> ACT(k); MULTI -> CONFLICT.
- ACT(k): ONE(k) -> ACT(k); ZERO -> IDLE; ONE(j), j != k -> IDLE (no direct channel-to-channel switch; ACT(j) only on the following edge if req still ONE(j)); MULTI -> CONFLICT.
- CONFLICT: clear counter clr_cnt increments on each ZERO cycle, resets to 0 on any nonzero req; when a ZERO cycle makes clr_cnt reach CLR_CYC, next state IDLE and clr_cnt <= 0. Any req other than ZERO keeps CONFLICT.
- y: in ACT(k), y = one-hot bit k gated by blink phase (see Configuration); all other states y = 0.
- fault = state[N_CH+1].
- Counter widths: clr_cnt and blink counter sized $clog2(max(CLR_CYC, BLINK_HALF)+1); no wrap beyond terminal values.

## Timing

- Reset (synchronous, dominates all transitions): state = IDLE (bit0 only), y = 0, fault = 0, clr_cnt = 0, blink counter = 0, phase = 1.
- Reset asserted mid-ACT or mid-CONFLICT: IDLE on the next edge, counters cleared, regardless of req.
- Latency: req sampled at edge t -> state/y/fault change visible after edge t (1 clock). y, state, fault decoded from registers only; no combinational path from req to outputs.
- Simultaneous events: MULTI takes priority over every other classification; a ZERO cycle completing CLR_CYC and a new request cannot coincide (request breaks the ZERO run).
- CLR_CYC = 1: a single ZERO cycle in CONFLICT returns to IDLE on that edge.

## Configuration

- OHR_BLINK_EN defined: on entry to ACT(k) phase = 1 and blink counter = 0; counter increments each cycle in ACT(k); at BLINK_HALF-1 it reloads 0 and phase toggles. y[k] = phase. Leaving ACT(k) resets counter to 0 and phase to 1. BLINK_HALF = 1 toggles every cycle.
- OHR_BLINK_EN undefined: no blink counter or phase register; y[k] = 1 steadily in ACT(k). All other behaviour identical.

## Test plan

- Reset: N_CH=4, drive req=4'b1010 with reset high for 3 cycles -> state=6'b000001, y=0, fault=0 every cycle; release with req=0 -> stays IDLE.
- Single request: req=4'b0100 for 6 cycles, then 0 -> state=6'b001000 one edge after assertion, y=4'b0100 (steady without blink), IDLE one edge after release.
- Channel switch: ACT(0) held, then req=4'b0010 -> one cycle IDLE (y=0), then ACT(1), y=4'b0010.
- Conflict and clear, CLR_CYC=3: req=4'b0011 -> CONFLICT, fault=1; req=0 for 2 cycles, req=4'b0001 one cycle, req=0 for 3 cycles -> fault stays 1 until 3rd consecutive zero edge, then IDLE, fault=0.
- Blink (OHR_BLINK_EN, BLINK_HALF=4): req=4'b1000 held 16 cycles -> y[3] pattern 1111 0000 1111 0000 starting the cycle after ACT(3) entry; drop and reassert req -> pattern restarts at 1.
- Reset mid-CONFLICT with req=4'b1111 held -> IDLE after reset edge, then CONFLICT again one edge after reset deasserts.

Source files
------------

// File: rtl/onehot_req_fsm.sv
// onehot_req_fsm: one-hot request state machine.
// Accepts exactly one of N_CH request lines and holds ACT(k) while that request
// persists. It returns to IDLE when the requests drop. Two or more simultaneous
// requests trap it in CONFLICT, which clears after CLR_CYC consecutive
// all-zero request cycles.
// Optional feature macro: OHR_BLINK_EN (blink modulation of the active output).
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   req   - request lines, bit k = channel k
//   y     - channel outputs, at most one bit high (registered)
//   state - one-hot state: bit0 IDLE, bit k+1 ACT(k), bit N_CH+1 CONFLICT (registered)
//   fault - high while in CONFLICT (registered)
module onehot_req_fsm #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned BLINK_HALF = 8,
  parameter int unsigned CLR_CYC    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   req,
  output logic [N_CH-1:0]   y,
  output logic [N_CH+1:0]   state,
  output logic              fault
);

  localparam int unsigned CNT_MAX = (CLR_CYC > BLINK_HALF) ? CLR_CYC : BLINK_HALF;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned CHW     = $clog2(N_CH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACT      = 2'd1,
    S_CONFLICT = 2'd2
  } mode_t;

  mode_t           mode, nxt_mode;
  logic [CHW-1:0]  ch, nxt_ch;
  logic [CW-1:0]   clr_cnt, nxt_clr;
  logic [N_CH+1:0] nxt_state;
  logic [N_CH-1:0] nxt_ch_oh;

  // Request classification: ZERO, ONE(idx), MULTI.
  logic            req_zero, req_multi, req_one;
  logic [CHW-1:0]  req_idx;

  always_comb begin
    req_zero  = ~|req;
    // Clearing the lowest set bit leaves something only if two or more were set.
    req_multi = |(req & (req - N_CH'(1)));
    req_one   = ~req_zero & ~req_multi;
    req_idx   = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (req[k]) req_idx = CHW'(k);
    end
  end

  // Next-state, clear counter and one-hot decode of the next state.
  always_comb begin
    nxt_mode = mode;
    nxt_ch   = ch;
    nxt_clr  = '0;
    unique case (mode)
      S_IDLE: begin
        if (req_multi) begin
          nxt_mode = S_CONFLICT;
        end else if (req_one) begin
          nxt_mode = S_ACT;
          nxt_ch   = req_idx;
        end
      end
      S_ACT: begin
        // A different single request drops to IDLE first; no direct switch.
        if (req_multi)                    nxt_mode = S_CONFLICT;
        else if (req_one && req_idx == ch) nxt_mode = S_ACT;
        else                              nxt_mode = S_IDLE;
      end
      S_CONFLICT: begin
        if (req_zero) begin
          if (clr_cnt == CW'(CLR_CYC - 1)) nxt_mode = S_IDLE;
          else                             nxt_clr  = clr_cnt + CW'(1);
        end
      end
      default: nxt_mode = S_IDLE;
    endcase

    nxt_state         = '0;
    nxt_state[0]      = (nxt_mode == S_IDLE);
    nxt_state[N_CH+1] = (nxt_mode == S_CONFLICT);
    for (int k = 0; k < N_CH; k++) begin
      nxt_ch_oh[k]   = (nxt_mode == S_ACT) && (nxt_ch == CHW'(k));
      nxt_state[k+1] = nxt_ch_oh[k];
    end
  end

`ifdef OHR_BLINK_EN
  logic [CW-1:0] blk_cnt, nxt_blk;
  logic          phase, nxt_phase;

  // Blink runs only while staying in the same ACT(k); entry restarts at phase 1.
  always_comb begin
    nxt_blk   = '0;
    nxt_phase = 1'b1;
    if (mode == S_ACT && nxt_mode == S_ACT) begin
      if (blk_cnt == CW'(BLINK_HALF - 1)) begin
        nxt_blk   = '0;
        nxt_phase = ~phase;
      end else begin
        nxt_blk   = blk_cnt + CW'(1);
        nxt_phase = phase;
      end
    end
  end
`endif

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode    <= S_IDLE;
      ch      <= '0;
      clr_cnt <= '0;
      state   <= (N_CH+2)'(1);
      y       <= '0;
      fault   <= 1'b0;
`ifdef OHR_BLINK_EN
      blk_cnt <= '0;
      phase   <= 1'b1;
`endif
    end else begin
      mode    <= nxt_mode;
      ch      <= nxt_ch;
      clr_cnt <= nxt_clr;
      state   <= nxt_state;
      fault   <= (nxt_mode == S_CONFLICT);
`ifdef OHR_BLINK_EN
      blk_cnt <= nxt_blk;
      phase   <= nxt_phase;
      y       <= nxt_phase ? nxt_ch_oh : '0;
`else
      y       <= nxt_ch_oh;
`endif
    end
  end

endmodule

// File: tb/tb_onehot_req_fsm.sv
// Testbench for onehot_req_fsm (N_CH=4, BLINK_HALF=4, CLR_CYC=3).
// A behavioural model tracks the active channel, the zero-run length and the
// time spent in the active state. Outputs are compared on every falling edge.
// Directed sequences add literal expectations.
module tb_onehot_req_fsm;

  localparam int N  = 4;
  localparam int BH = 4;
  localparam int CC = 3;
  localparam int M_IDLE = -1;
  localparam int M_CONF = N;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] y;
  logic [N+1:0] state;
  logic         fault;

  int vectors = 0;
  int miscompares = 0;

  onehot_req_fsm #(.N_CH(N), .BLINK_HALF(BH), .CLR_CYC(CC)) dut (
    .clk(clk), .reset(reset), .req(req), .y(y), .state(state), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model.
  int mode = M_IDLE;
  int zrun = 0;
  int act_cyc = 0;
  bit model_valid = 1'b0;

  always @(posedge clk) begin
    int ones, idx;
    ones = 0; idx = 0;
    for (int k = 0; k < N; k++) if (req[k]) begin ones++; idx = k; end
    if (reset) begin
      mode = M_IDLE; zrun = 0; act_cyc = 0; model_valid = 1'b1;
    end else if (ones >= 2) begin
      mode = M_CONF; zrun = 0;
    end else if (mode == M_CONF) begin
      if (ones == 0) begin
        zrun++;
        if (zrun == CC) begin mode = M_IDLE; zrun = 0; end
      end else begin
        zrun = 0;
      end
    end else if (mode == M_IDLE) begin
      if (ones == 1) begin mode = idx; act_cyc = 0; end
    end else begin
      if (ones == 1 && idx == mode) act_cyc++;
      else mode = M_IDLE;
    end
  end

  function automatic logic [N+1:0] exp_state();
    logic [N+1:0] s;
    s = '0;
    if (mode == M_IDLE)      s[0] = 1'b1;
    else if (mode == M_CONF) s[N+1] = 1'b1;
    else                     s[mode+1] = 1'b1;
    return s;
  endfunction

  function automatic logic [N-1:0] exp_y();
    logic [N-1:0] v;
    v = '0;
    if (mode >= 0 && mode < N) begin
`ifdef OHR_BLINK_EN
      v[mode] = ((act_cyc / BH) % 2) == 0;
`else
      v[mode] = 1'b1;
`endif
    end
    return v;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("model_state", 32'(state), 32'(exp_state()));
      chk("model_y",     32'(y),     32'(exp_y()));
      chk("model_fault", 32'(fault), 32'(mode == M_CONF));
    end
  end

  task automatic drive(input logic [N-1:0] r, input logic rs);
    @(negedge clk);
    req = r; reset = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] pat;
    logic [N-1:0] r;
    pat = 16'b1111000011110000;

    // Reset with requests pending.
    for (int i = 0; i < 3; i++) begin
      drive(4'b1010, 1'b1);
      chk("rst_state", 32'(state), 32'h01);
      chk("rst_y", 32'(y), 32'h0);
      chk("rst_fault", 32'(fault), 32'h0);
    end
    drive(4'b0000, 1'b0);
    chk("rel_state", 32'(state), 32'h01);

    // Single request held, then released.
    drive(4'b0100, 1'b0);
    chk("one_state", 32'(state), 32'h08);
    chk("one_y", 32'(y), 32'h4);
    for (int i = 0; i < 5; i++) begin
      drive(4'b0100, 1'b0);
      chk("one_hold", 32'(state), 32'h08);
    end
    drive(4'b0000, 1'b0);
    chk("one_rel", 32'(state), 32'h01);

    // Channel switch passes through IDLE.
    drive(4'b0001, 1'b0);
    chk("sw_act0", 32'(state), 32'h02);
    drive(4'b0010, 1'b0);
    chk("sw_idle", 32'(state), 32'h01);
    chk("sw_idle_y", 32'(y), 32'h0);
    drive(4'b0010, 1'b0);
    chk("sw_act1", 32'(state), 32'h04);
    chk("sw_act1_y", 32'(y), 32'h2);

    // Conflict with broken and complete zero runs.
    drive(4'b0011, 1'b0);
    chk("cf_state", 32'(state), 32'h20);
    chk("cf_fault", 32'(fault), 32'h1);
    drive(4'b0000, 1'b0); chk("cf_z1", 32'(fault), 32'h1);
    drive(4'b0000, 1'b0); chk("cf_z2", 32'(fault), 32'h1);
    drive(4'b0001, 1'b0); chk("cf_brk", 32'(fault), 32'h1);
    drive(4'b0000, 1'b0); chk("cf_z1b", 32'(fault), 32'h1);
    drive(4'b0000, 1'b0); chk("cf_z2b", 32'(fault), 32'h1);
    drive(4'b0000, 1'b0);
    chk("cf_clr_state", 32'(state), 32'h01);
    chk("cf_clr_fault", 32'(fault), 32'h0);

    // Long hold on channel 3 (blink pattern when enabled), then re-entry.
    for (int i = 0; i < 16; i++) begin
      drive(4'b1000, 1'b0);
`ifdef OHR_BLINK_EN
      chk("blink_y3", 32'(y[3]), 32'(pat[15-i]));
`else
      chk("steady_y3", 32'(y[3]), 32'h1);
`endif
    end
    drive(4'b0000, 1'b0);
    drive(4'b1000, 1'b0);
    chk("reentry_y", 32'(y), 32'h8);

    // Reset in CONFLICT with all requests held.
    drive(4'b1111, 1'b0);
    chk("rc_conf", 32'(state), 32'h20);
    drive(4'b1111, 1'b1);
    chk("rc_idle", 32'(state), 32'h01);
    chk("rc_fault", 32'(fault), 32'h0);
    drive(4'b1111, 1'b0);
    chk("rc_reconf", 32'(state), 32'h20);

    // Randomised traffic, biased toward zero and single requests with holds.
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) >= 70) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: r = '0;
          4, 5, 6, 7: begin r = '0; r[$urandom_range(0, N-1)] = 1'b1; end
          default:    r = N'($urandom);
        endcase
      end
      req = r;
      reset = ($urandom_range(0, 99) < 2);
    end
    @(negedge clk);
    reset = 1'b0; req = '0;
    repeat (2) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
